// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM responder: funct3 codes, FSM encoding and
// the byte-lane / load-formatting helpers used by the top level.
package dram_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Misaligned access or a funct3 code outside the legal set.
  function automatic logic access_err(input logic [2:0] ctrl, input logic [1:0] off);
    logic bad;
    case (ctrl)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] be_from_ctrl(input logic [2:0] ctrl, input logic [1:0] off);
    logic [3:0] be;
    case (ctrl[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] ctrl, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (ctrl)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   res = {24'h000000, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   res = {16'h0000, sh[15:0]};
      F3_W:    res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dram_bram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and a
// registered read port gated by en.
module dram_bram #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder: one load/store at a time on the busy handshake,
// serviced from on-chip RAM after a fixed LATENCY.
module dram_responder
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic [2:0]  w_dram_ctrl,
  input  logic        w_dram_le,
  input  logic        w_dram_we_t,
  output logic        w_dram_busy,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_err
);

  localparam int unsigned BYTE_AW = ADDR_WIDTH + 2;

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q;
  logic               op_write_q;
  logic [BYTE_AW-1:0] addr_q;
  logic [2:0]         ctrl_q;
  logic [31:0]        wdata_q;

  logic               accept_c;
  logic               bad_c;
  logic               ram_en_c;
  logic [3:0]         ram_we_c;
  logic [31:0]        ram_wdata_c;
  logic [31:0]        ram_rdata;
  logic               unused_addr_c;

  // Address bits above the RAM capacity are dropped so accesses wrap.
  assign unused_addr_c = ^w_dram_addr[31:BYTE_AW];

  assign accept_c = (state_q == ST_IDLE) && (w_dram_le || w_dram_we_t);
  assign bad_c    = access_err(ctrl_q, addr_q[1:0]);

  // The RAM output register doubles as the holding register: loaded on the
  // first ACCESS cycle only, then stable until FINISH.
  assign ram_en_c = (state_q == ST_ACCESS) && (cnt_q == 8'(LATENCY - 1));
  assign ram_we_c = (state_q == ST_FINISH && op_write_q && !bad_c)
                    ? be_from_ctrl(ctrl_q, addr_q[1:0]) : 4'b0000;

  always_comb begin
    ram_wdata_c = wdata_q;
    case (ctrl_q[1:0])
      2'b00:   ram_wdata_c = {4{wdata_q[7:0]}};
      2'b01:   ram_wdata_c = {2{wdata_q[15:0]}};
      default: ram_wdata_c = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_dram_le || w_dram_we_t) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == 8'd1) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      ctrl_q       <= 3'b000;
      wdata_q      <= 32'h0000_0000;
      w_dram_busy  <= 1'b0;
      w_dram_odata <= 32'h0000_0000;
      w_dram_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_dram_err <= (state_q == ST_FINISH) && bad_c;
      if (accept_c) begin
        addr_q      <= w_dram_addr[BYTE_AW-1:0];
        ctrl_q      <= w_dram_ctrl;
        op_write_q  <= !w_dram_le;
        if (!w_dram_le) wdata_q <= w_dram_wdata;
        w_dram_busy <= 1'b1;
        cnt_q       <= 8'(LATENCY - 1);
      end
      if (state_q == ST_ACCESS) cnt_q <= cnt_q - 8'd1;
      if (state_q == ST_FINISH) begin
        w_dram_busy <= 1'b0;
        if (!op_write_q) begin
          w_dram_odata <= bad_c ? 32'h0000_0000
                                : load_extend(ctrl_q, addr_q[1:0], ram_rdata);
        end
      end
    end
  end

  dram_bram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk  (CLK),
    .en   (ram_en_c),
    .we   (ram_we_c),
    .addr (addr_q[BYTE_AW-1:2]),
    .wdata(ram_wdata_c),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: directed scenarios plus randomized traffic checked
// against a byte-array memory model.
module tb_dram_responder;

  localparam int unsigned LAT = 4;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_le;
  logic        w_dram_we_t;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;
  logic        w_dram_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mdl [65536];
  logic [31:0] exp_odata;

  dram_responder #(.ADDR_WIDTH(14), .LATENCY(LAT)) dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .w_dram_addr (w_dram_addr),
    .w_dram_wdata(w_dram_wdata),
    .w_dram_ctrl (w_dram_ctrl),
    .w_dram_le   (w_dram_le),
    .w_dram_we_t (w_dram_we_t),
    .w_dram_busy (w_dram_busy),
    .w_dram_odata(w_dram_odata),
    .w_dram_err  (w_dram_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] c);
    return 1 << c[1:0];
  endfunction

  function automatic logic is_bad(input logic [2:0] c, input logic [31:0] addr);
    if (c == 3'd3 || c == 3'd6 || c == 3'd7) return 1'b1;
    return (addr % acc_size(c)) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] c, input logic [31:0] addr);
    int unsigned a, n;
    logic [63:0] v;
    a = addr & 32'hFFFF;
    n = acc_size(c);
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(mdl[(a + i) & 32'hFFFF]) << (8 * i));
    if (!c[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic mdl_store(input logic [2:0] c, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned a;
    a = addr & 32'hFFFF;
    for (int i = 0; i < acc_size(c); i++) mdl[(a + i) & 32'hFFFF] = 8'(wd >> (8 * i));
  endtask

  // One full handshake; hold = extra cycles the strobes stay high after busy rises.
  task automatic do_op(input string tag, input logic le, input logic we, input logic [2:0] c,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int  n;
    logic bad;
    bad = is_bad(c, addr);
    @(negedge CLK);
    w_dram_le = le; w_dram_we_t = we; w_dram_ctrl = c;
    w_dram_addr = addr; w_dram_wdata = wd;
    @(negedge CLK);
    check({tag, ":busy_rise"}, 32'(w_dram_busy), 32'd1);
    if (hold == 0) begin w_dram_le = 1'b0; w_dram_we_t = 1'b0; end
    n = 1;
    while (n < int'(LAT) + 20) begin
      @(negedge CLK);
      if (n >= hold) begin w_dram_le = 1'b0; w_dram_we_t = 1'b0; end
      if (!w_dram_busy) break;
      if (w_dram_err) check({tag, ":err_early"}, 32'(w_dram_err), 32'd0);
      n++;
    end
    check({tag, ":busy_len"}, 32'(n), 32'(LAT));
    if (le) exp_odata = bad ? 32'h0 : mdl_load(c, addr);
    else if (!bad) mdl_store(c, addr, wd);
    check({tag, ":odata"}, w_dram_odata, exp_odata);
    check({tag, ":err"}, 32'(w_dram_err), 32'(bad));
    @(negedge CLK);
    check({tag, ":err_clear"}, 32'(w_dram_err), 32'd0);
    check({tag, ":idle"}, 32'(w_dram_busy), 32'd0);
  endtask

  initial begin
    logic [2:0]  c;
    logic [31:0] a, d;
    logic        ld;
    RST_X = 1'b0;
    w_dram_le = 1'b0; w_dram_we_t = 1'b0; w_dram_ctrl = 3'b000;
    w_dram_addr = 32'h0; w_dram_wdata = 32'h0;
    exp_odata = 32'h0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(w_dram_busy), 32'd0);
    check("rst_odata", w_dram_odata, 32'h0);
    check("rst_err", 32'(w_dram_err), 32'd0);
    RST_X = 1'b1;

    do_op("sw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
    do_op("lw100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    check("lw100_val", w_dram_odata, 32'hDEADBEEF);

    do_op("sw200", 1'b0, 1'b1, 3'b010, 32'h200, 32'h80FF7F01, 0);
    do_op("lb203", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0);
    check("lb203_val", w_dram_odata, 32'hFFFFFF80);
    do_op("lbu203", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0);
    check("lbu203_val", w_dram_odata, 32'h00000080);
    do_op("lh202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0);
    check("lh202_val", w_dram_odata, 32'hFFFF80FF);
    do_op("lhu200", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 0);
    check("lhu200_val", w_dram_odata, 32'h00007F01);

    do_op("sb201", 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AA, 0);
    do_op("lw200", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0);
    check("lw200_val", w_dram_odata, 32'h80FFAA01);

    do_op("lw102_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0);
    do_op("sh101_mis", 1'b0, 1'b1, 3'b001, 32'h101, 32'h5555, 0);
    do_op("lw100_after", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    check("lw100_unch", w_dram_odata, 32'hDEADBEEF);

    do_op("lw200_held", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 3);
    do_op("both_strb", 1'b1, 1'b1, 3'b010, 32'h100, 32'h12345678, 0);
    do_op("lw100_nowr", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    check("both_nowr", w_dram_odata, 32'hDEADBEEF);

    // Reset in the middle of a store: the write must be dropped.
    do_op("sw300", 1'b0, 1'b1, 3'b010, 32'h300, 32'h01234567, 0);
    @(negedge CLK);
    w_dram_we_t = 1'b1; w_dram_ctrl = 3'b010; w_dram_addr = 32'h300; w_dram_wdata = 32'hFFFF0000;
    @(negedge CLK);
    w_dram_we_t = 1'b0;
    @(negedge CLK);
    RST_X = 1'b0;
    #1;
    check("midrst_busy", 32'(w_dram_busy), 32'd0);
    check("midrst_odata", w_dram_odata, 32'h0);
    check("midrst_err", 32'(w_dram_err), 32'd0);
    exp_odata = 32'h0;
    @(negedge CLK);
    RST_X = 1'b1;
    do_op("lw300", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0);
    check("lw300_unch", w_dram_odata, 32'h01234567);

    do_op("sw_wrap", 1'b0, 1'b1, 3'b010, 32'h10100, 32'hCAFEF00D, 0);
    do_op("lw_wrap", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    check("wrap_val", w_dram_odata, 32'hCAFEF00D);

    for (int i = 0; i < 16; i++) do_op("init", 1'b0, 1'b1, 3'b010, 32'(4 * i), $urandom, 0);
    for (int i = 0; i < 60; i++) begin
      ld = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 60));
      d  = $urandom;
      case ($urandom_range(0, 9))
        0:       c = 3'($urandom_range(6, 7));
        1:       c = 3'd3;
        default: c = ld ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
      endcase
      if (ld && c == 3'd3 && $urandom_range(0, 1) == 0) c = 3'd4;
      do_op(ld ? "rnd_ld" : "rnd_st", ld, !ld, c, a, d, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
